// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the single async_fifo1 write port between NREQ
// valid/ready producers; bursts of up to MAX_BURST words, one arbitration cycle each.
module fifo_wr_arbiter #(
   parameter int DSIZE     = 8,
   parameter int NREQ      = 4,
   parameter int MAX_BURST = 4
) (
   input  logic                  wclk,
   input  logic                  wrst,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*DSIZE-1:0] req_data,
   output logic [NREQ-1:0]       req_ready,
   input  logic                  wfull,
   output logic                  winc,
   output logic [DSIZE-1:0]      wdata,
   output logic [NREQ-1:0]       grant,
   output logic                  busy
);

   localparam int IW = $clog2(NREQ);
   localparam int BW = $clog2(MAX_BURST + 1);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] GRANT = 1'b1;

   logic [0:0]       state;
   logic [IW-1:0]    last;
   logic [BW-1:0]    bcnt;

   logic [IW-1:0]    gidx;
   logic             own_valid;
   logic [DSIZE-1:0] own_data;
   logic [IW-1:0]    nxt_idx;
   logic             xfer;
   logic             release_g;

   // Owner index, valid and data decoded from the one-hot grant; all zero when idle.
   always_comb begin
      gidx      = '0;
      own_valid = 1'b0;
      own_data  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            gidx      = IW'(i);
            own_valid = req_valid[i];
            own_data  = req_data[i*DSIZE +: DSIZE];
         end
      end
   end

   // Circular search starting one past the previous owner.
   always_comb begin
      logic found;
      int   idx;
      found   = 1'b0;
      nxt_idx = '0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = (int'(last) + k) % NREQ;
         if (!found && req_valid[idx]) begin
            found   = 1'b1;
            nxt_idx = IW'(idx);
         end
      end
   end

   assign busy      = (state == GRANT);
   assign xfer      = busy & own_valid & ~wfull & ~wrst;
   assign winc      = xfer;
   assign req_ready = xfer ? grant : '0;
   assign wdata     = own_data;
   // A stalled owner (valid but full) keeps the grant indefinitely.
   assign release_g = busy & ((xfer & (bcnt == BW'(MAX_BURST - 1))) | ~own_valid);

   always_ff @(posedge wclk) begin
      if (wrst) begin
         state <= IDLE;
         grant <= '0;
         bcnt  <= '0;
         last  <= IW'(NREQ - 1);
      end else begin
         case (state)
            IDLE: begin
               if (|req_valid) begin
                  state <= GRANT;
                  grant <= NREQ'(1) << nxt_idx;
                  bcnt  <= '0;
               end
            end
            GRANT: begin
               if (release_g) begin
                  state <= IDLE;
                  grant <= '0;
                  bcnt  <= '0;
                  last  <= gidx;
               end else if (xfer) begin
                  bcnt  <= bcnt + BW'(1);
               end
            end
            default: begin
               state <= IDLE;
               grant <= '0;
               bcnt  <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized bench for fifo_wr_arbiter: transaction-level reference model plus
// a write-side FIFO capture checked per requester for order, loss and duplication.
module tb_fifo_wr_arbiter;

   localparam int DSIZE     = 8;
   localparam int NREQ      = 4;
   localparam int MAX_BURST = 4;

   logic                  wclk = 1'b0;
   logic                  wrst;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ*DSIZE-1:0] req_data;
   logic [NREQ-1:0]       req_ready;
   logic                  wfull;
   logic                  winc;
   logic [DSIZE-1:0]      wdata;
   logic [NREQ-1:0]       grant;
   logic                  busy;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: who owns the port, who owned it last, words sent this burst.
   int m_busy, m_owner, m_last, m_cnt;
   int seq [NREQ];
   int got_cnt [NREQ];

   int               fq_owner [$];
   logic [DSIZE-1:0] fq_data  [$];

   fifo_wr_arbiter #(.DSIZE(DSIZE), .NREQ(NREQ), .MAX_BURST(MAX_BURST)) dut (
      .wclk      (wclk),
      .wrst      (wrst),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .wfull     (wfull),
      .winc      (winc),
      .wdata     (wdata),
      .grant     (grant),
      .busy      (busy)
   );

   always #5 wclk = ~wclk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [DSIZE-1:0] word_of(input int id, input int s);
      return DSIZE'((id << 6) | (s & 63));
   endfunction

   task automatic drive_data();
      for (int i = 0; i < NREQ; i++) req_data[i*DSIZE +: DSIZE] = word_of(i, seq[i]);
   endtask

   // One clock: check outputs at negedge, advance model and producers after the edge.
   task automatic step(input int valid_pct, input int full_mode, input int rst_pct);
      logic v;
      logic exp_xfer;
      int   c;
      @(negedge wclk);
      v        = (m_busy != 0) ? req_valid[m_owner] : 1'b0;
      exp_xfer = (m_busy != 0) && v && !wfull && !wrst;
      chk("busy",      {31'd0, busy}, m_busy);
      chk("grant",     {28'd0, grant}, (m_busy != 0) ? (1 << m_owner) : 0);
      chk("winc",      {31'd0, winc}, {31'd0, exp_xfer});
      chk("req_ready", {28'd0, req_ready}, exp_xfer ? (1 << m_owner) : 0);
      chk("wdata",     {24'd0, wdata},
          (m_busy != 0) ? {24'd0, req_data[m_owner*DSIZE +: DSIZE]} : 32'd0);
      if (winc === 1'b1) begin
         fq_owner.push_back(m_owner);
         fq_data.push_back(wdata);
      end
      @(posedge wclk);
      #1;
      if (wrst) begin
         m_busy = 0;
         m_last = NREQ - 1;
         m_cnt  = 0;
      end else if (m_busy == 0) begin
         if (|req_valid) begin
            for (int k = 1; k <= NREQ; k++) begin
               c = (m_last + k) % NREQ;
               if (req_valid[c]) begin
                  m_owner = c;
                  break;
               end
            end
            m_busy = 1;
            m_cnt  = 0;
         end
      end else begin
         if (exp_xfer) m_cnt++;
         if (!v || (exp_xfer && m_cnt == MAX_BURST)) begin
            m_busy = 0;
            m_last = m_owner;
         end
      end
      // Producers hold valid and data until accepted, then pick a new word.
      for (int i = 0; i < NREQ; i++) begin
         if (exp_xfer && i == m_last && m_busy == 0) begin
            seq[i]++;
            req_valid[i] = ($urandom_range(0, 99) < valid_pct);
         end else if (exp_xfer && m_busy != 0 && i == m_owner) begin
            seq[i]++;
            req_valid[i] = ($urandom_range(0, 99) < valid_pct);
         end else if (!req_valid[i]) begin
            req_valid[i] = ($urandom_range(0, 99) < valid_pct);
         end
      end
      drive_data();
      if (full_mode == 0) wfull = 1'b0;
      else if ($urandom_range(0, 5) == 0) wfull = ~wfull;
      wrst = ($urandom_range(0, 99) < rst_pct);
   endtask

   initial begin
      int o;
      for (int i = 0; i < NREQ; i++) begin
         seq[i]     = 0;
         got_cnt[i] = 0;
      end
      wrst      = 1'b1;
      wfull     = 1'b0;
      req_valid = '1;
      drive_data();
      @(posedge wclk);
      #1;
      m_busy  = 0;
      m_owner = 0;
      m_last  = NREQ - 1;
      m_cnt   = 0;

      // Reset held with all requesters valid, then release: requester 0 first.
      step(100, 0, 100);
      step(100, 0, 100);
      step(100, 0, 0);
      for (int n = 0; n < 60; n++) step(100, 0, 0);
      // Sparse traffic: short bursts and early releases.
      for (int n = 0; n < 300; n++) step(30, 0, 0);
      // Random traffic with back-pressure runs and occasional reset pulses.
      for (int n = 0; n < 1200; n++) step(60, 1, 2);
      // Dense traffic with back-pressure, no reset.
      for (int n = 0; n < 400; n++) step(90, 1, 0);
      // Drain: producers finish outstanding words.
      for (int n = 0; n < 40; n++) step(0, 0, 0);

      while (fq_owner.size() > 0) begin
         o = fq_owner.pop_front();
         chk("fifo_word", {24'd0, fq_data.pop_front()}, {24'd0, word_of(o, got_cnt[o])});
         got_cnt[o]++;
      end
      for (int i = 0; i < NREQ; i++) chk("words_written", got_cnt[i], seq[i]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin arbiter that shares the single write port of `async_fifo1` between `NREQ` producers in the write-clock domain. Each producer presents words on a valid/ready handshake. The arbiter grants one producer at a time for a burst of up to `MAX_BURST` words, drives `winc`/`wdata` and honours `wfull` back-pressure. It sits directly in front of the FIFO write side and shares its clock.

## Interface
- `DSIZE`, 8, word width; must equal the FIFO `DSIZE`.
- `NREQ`, 4, number of requesters; range 2..8.
- `MAX_BURST`, 4, maximum words per grant; range 1..16.

- `wclk`  in  1  write-domain clock; all state updates on rising edge.
- `wrst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NREQ  bit i: requester i has a word on its data slice.
- `req_data`  in  NREQ*DSIZE  requester i word at bits [i*DSIZE +: DSIZE].
- `req_ready`  out  NREQ  bit i: word i is accepted this cycle.
- `wfull`  in  1  FIFO full flag, synchronised to `wclk`.
- `winc`  out  1  FIFO write enable.
- `wdata`  out  DSIZE  FIFO write data.
- `grant`  out  NREQ  one-hot registered owner; all zero when idle.
- `busy`  out  1  high while in GRANT.

## Operation
- FSM states are IDLE and GRANT. Registered state consists of the FSM state, `grant`, `last` (index of the previous owner) and `bcnt` (words sent in the current burst, width clog2(MAX_BURST+1)).
- **IDLE:** if any `req_valid` bit is set, select the first set bit searching circularly from `last+1`. Load `grant` with that index, clear `bcnt` and go to GRANT. Otherwise stay in IDLE.
- **GRANT**, owner g:
  - transfer condition `xfer = req_valid[g] & !wfull & !wrst`.
  - `winc = xfer`, `req_ready[g] = xfer`, and every other `req_ready` bit is 0.
  - `wdata = req_data[g]` while in GRANT; 0 in IDLE.
  - On `xfer`, increment `bcnt`.
  - Release when `xfer` occurs and `bcnt == MAX_BURST-1`, or when `req_valid[g]` is 0. Release sets `last <= g`, clears `grant` and returns to IDLE.
  - `wfull` high with `req_valid[g]` high is a stall: no release, `bcnt` holds, no timeout.
- Releases always pass through IDLE. Every burst is therefore preceded by exactly one arbitration cycle.
- A requester must hold `req_valid` and its data stable until `req_ready` is asserted. Dropping `req_valid` ends its burst early.
- **Reset** (synchronous, highest priority, any state):
  - State goes to IDLE, `grant` to 0, `bcnt` to 0, and `last` to NREQ-1, so requester 0 wins first.
  - `winc` and `req_ready` are combinationally forced to 0 while `wrst` is high. No word is accepted in the reset cycle, even from GRANT.
- **Reset values:** `winc` 0, `req_ready` 0, `wdata` 0, `grant` 0, `busy` 0.
- The block never asserts `winc` while `wfull` is high. The FIFO's own full guard is never relied on.

## Timing
- Arbitration latency: request seen in IDLE at edge N means `grant`/`busy` are valid after edge N+1, and the first word can transfer in the cycle following edge N+1.
- Transfer latency: zero. `winc`/`wdata` are combinational from `req_valid[g]`, `req_data[g]` and `wfull` within the granted cycle, and the FIFO samples them on the same `wclk` edge.
- Throughput: with `wfull` low, each burst of B words occupies B+1 cycles.
- Back-to-back different owners require one IDLE cycle between bursts.
- The `wfull` to `winc` path is combinational. The FIFO's registered `wfull` must meet this setup within one `wclk` cycle.

## Test plan
- **Reset and idle:** hold `wrst`=1 for 3 cycles with all `req_valid`=1 -> `winc`=0, `grant`=0, `req_ready`=0 throughout. Release reset -> `grant`=0001 one cycle later.
- **Round robin:** all four requesters continuously valid, `MAX_BURST`=4, `wfull`=0 -> grants 0,1,2,3,0; each burst is 4 `winc` pulses followed by 1 idle cycle. FIFO contents match each requester's words in order.
- **Early release:** requester 2 alone, 2 words, then `req_valid[2]`=0 -> 2 writes, release, IDLE. Requester 2 is re-granted next only if it is the only requester valid.
- **Back-pressure:** in mid-burst with `bcnt`=2, force `wfull`=1 for 5 cycles -> `winc`=0, `req_ready`=0, `grant` held, `bcnt`=2. On deassert the remaining 2 words transfer, then release.
- **Reset mid-burst:** pulse `wrst` during GRANT with `xfer` conditions true -> no `winc` in that cycle, IDLE after the edge, and the next grant goes to requester 0.
- **End-to-end:** drive the arbiter and `async_fifo1` with `rclk` at half the `wclk` rate and random `req_valid` for 500 cycles. A scoreboard keeps per-requester queues, and every `rdata` must match the head of the queue for the owner tagged at write time, with no loss or duplication.
